mac_entry_ctrl: RTL and testbench

MAC_ENTRY_CTRL -- requirements
Module: mac_entry_ctrl

---
 rtl/mac_entry_if.sv | 31 +++
 rtl/mac_entry_ctrl.sv | 146 ++++++++++++++
 tb/tb_mac_entry_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_entry_if.sv
// Keypad, display and FP MAC handshake signals of the MAC entry controller.
// The master modport is the controller; slave is the surrounding system.
interface mac_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        btn_enter;
    logic        btn_clear;
    logic        mac_ready;
    logic        mac_done;
    logic [15:0] mac_result;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mac_start;
    logic [15:0] display;
    logic [2:0]  state_code;
    logic [2:0]  digits;
    logic        busy;
    logic        error;

    modport master (
        input  key_valid, key_code, btn_enter, btn_clear,
        input  mac_ready, mac_done, mac_result,
        output op_a, op_b, mac_start, display, state_code, digits, busy, error
    );

    modport slave (
        output key_valid, key_code, btn_enter, btn_clear,
        output mac_ready, mac_done, mac_result,
        input  op_a, op_b, mac_start, display, state_code, digits, busy, error
    );
endinterface

// File: rtl/mac_entry_ctrl.sv
// Keypad entry of two 16-bit operands, hand-off to an FP MAC with a timeout,
// and display of the result or an 0xEEEE error pattern.
module mac_entry_ctrl #(
    parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    mac_entry_if.master bus
);
    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4
    } state_e;

    state_e      state, state_n;
    logic [15:0] entry_buf, entry_buf_n;
    logic [2:0]  digits, digits_n;
    logic [15:0] op_a, op_a_n;
    logic [15:0] op_b, op_b_n;
    logic [15:0] display, display_n;
    logic        error, error_n;
    logic        mac_start, mac_start_n;
    logic [23:0] timer, timer_n;

    // NOTE: every next-value is defaulted to its current value first, so no
    // path through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        entry_buf_n = entry_buf;
        digits_n    = digits;
        op_a_n      = op_a;
        op_b_n      = op_b;
        display_n   = display;
        error_n     = error;
        mac_start_n = 1'b0;
        timer_n     = timer;

        if (bus.btn_clear) begin
            state_n     = ENTER_A;
            entry_buf_n = 16'h0000;
            digits_n    = 3'd0;
            op_a_n      = 16'h0000;
            op_b_n      = 16'h0000;
            display_n   = 16'h0000;
            error_n     = 1'b0;
            timer_n     = 24'd0;
        end else begin
            case (state)
                ENTER_A, ENTER_B: begin
                    if (bus.btn_enter) begin
                        entry_buf_n = 16'h0000;
                        digits_n    = 3'd0;
                        if (state == ENTER_A) begin
                            op_a_n    = entry_buf;
                            display_n = 16'h0000;
                            state_n   = ENTER_B;
                        end else begin
                            op_b_n    = entry_buf;
                            display_n = entry_buf;
                            state_n   = ISSUE;
                        end
                    end else if (bus.key_valid) begin
                        entry_buf_n = {entry_buf[11:0], bus.key_code};
                        digits_n    = (digits == 3'd4) ? 3'd4 : digits + 3'd1;
                        display_n   = {entry_buf[11:0], bus.key_code};
                    end
                end
                ISSUE: begin
                    if (bus.mac_ready) begin
                        mac_start_n = 1'b1;
                        timer_n     = 24'd0;
                        state_n     = WAIT;
                    end
                end
                WAIT: begin
                    // mac_start is registered, so a done seen alongside it
                    // cannot belong to this operation.
                    if (bus.mac_done && !mac_start) begin
                        display_n = bus.mac_result;
                        state_n   = SHOW;
                    end else if (timer == TIMEOUT - 24'd1) begin
                        error_n   = 1'b1;
                        display_n = 16'hEEEE;
                        state_n   = SHOW;
                    end else begin
                        timer_n = timer + 24'd1;
                    end
                end
                SHOW: begin
                    if (bus.btn_enter) begin
                        entry_buf_n = 16'h0000;
                        digits_n    = 3'd0;
                        display_n   = 16'h0000;
                        error_n     = 1'b0;
                        state_n     = ENTER_A;
                    end else if (bus.key_valid) begin
                        entry_buf_n = {12'h000, bus.key_code};
                        digits_n    = 3'd1;
                        display_n   = {12'h000, bus.key_code};
                        error_n     = 1'b0;
                        state_n     = ENTER_A;
                    end
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ENTER_A;
            entry_buf <= 16'h0000;
            digits    <= 3'd0;
            op_a      <= 16'h0000;
            op_b      <= 16'h0000;
            display   <= 16'h0000;
            error     <= 1'b0;
            mac_start <= 1'b0;
            timer     <= 24'd0;
        end else begin
            state     <= state_n;
            entry_buf <= entry_buf_n;
            digits    <= digits_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            display   <= display_n;
            error     <= error_n;
            mac_start <= mac_start_n;
            timer     <= timer_n;
        end
    end

    assign bus.op_a       = op_a;
    assign bus.op_b       = op_b;
    assign bus.mac_start  = mac_start;
    assign bus.display    = display;
    assign bus.state_code = state;
    assign bus.digits     = digits;
    assign bus.busy       = (state == ISSUE) || (state == WAIT);
    assign bus.error      = error;
endmodule

// File: tb/tb_mac_entry_ctrl.sv
// Directed bench for mac_entry_ctrl with a short timeout; expected values are
// hand-derived constants checked by immediate assertions.
module tb_mac_entry_ctrl;
    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   cnt;

    mac_entry_if bus ();

    mac_entry_ctrl #(.TIMEOUT(24'd16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses applied, then sample #1 after the edge.
    task automatic step(input logic kv, input logic [3:0] k, input logic en, input logic clr);
        bus.key_valid = kv;
        bus.key_code  = k;
        bus.btn_enter = en;
        bus.btn_clear = clr;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic enter();
        step(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.btn_enter  = 1'b0;
        bus.btn_clear  = 1'b0;
        bus.mac_ready  = 1'b0;
        bus.mac_done   = 1'b0;
        bus.mac_result = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {13'd0, bus.state_code}, 16'd0);
        check("rst_display", bus.display, 16'h0000);
        check("rst_op_a", bus.op_a, 16'h0000);
        check("rst_flags", {12'd0, bus.busy, bus.error, bus.mac_start, 1'b0}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic A/B entry and issue
        key(4'h1); key(4'h2); key(4'h3);
        check("digits_3", {13'd0, bus.digits}, 16'd3);
        key(4'h4);
        check("disp_1234", bus.display, 16'h1234);
        check("digits_4", {13'd0, bus.digits}, 16'd4);
        enter();
        check("op_a_1234", bus.op_a, 16'h1234);
        check("state_b", {13'd0, bus.state_code}, 16'd1);
        check("disp_clr_b", bus.display, 16'h0000);
        key(4'hA); key(4'hB); key(4'hC); key(4'hD);
        check("disp_abcd", bus.display, 16'hABCD);
        enter();
        check("op_b_abcd", bus.op_b, 16'hABCD);
        check("state_issue", {13'd0, bus.state_code}, 16'd2);
        check("busy_issue", {15'd0, bus.busy}, 16'd1);

        // Stall in ISSUE while MAC not ready
        for (int i = 0; i < 10; i++) begin
            idle();
            check("no_start_stall", {15'd0, bus.mac_start}, 16'd0);
        end
        check("still_issue", {13'd0, bus.state_code}, 16'd2);
        bus.mac_ready = 1'b1;
        idle();
        check("start_pulse", {15'd0, bus.mac_start}, 16'd1);
        check("state_wait", {13'd0, bus.state_code}, 16'd3);
        check("busy_wait", {15'd0, bus.busy}, 16'd1);

        // Done coincident with the start cycle is ignored
        bus.mac_done   = 1'b1;
        bus.mac_result = 16'h1111;
        idle();
        bus.mac_done = 1'b0;
        check("start_once", {15'd0, bus.mac_start}, 16'd0);
        check("coinc_done_ign", {13'd0, bus.state_code}, 16'd3);
        check("disp_op_b", bus.display, 16'hABCD);

        // Keys and enter ignored in WAIT
        key(4'h9);
        enter();
        check("wait_ign_state", {13'd0, bus.state_code}, 16'd3);
        check("wait_ign_disp", bus.display, 16'hABCD);
        check("no_restart", {15'd0, bus.mac_start}, 16'd0);

        bus.mac_done   = 1'b1;
        bus.mac_result = 16'h3C00;
        idle();
        bus.mac_done  = 1'b0;
        bus.mac_ready = 1'b0;
        check("disp_result", bus.display, 16'h3C00);
        check("state_show", {13'd0, bus.state_code}, 16'd4);
        check("busy_show", {15'd0, bus.busy}, 16'd0);
        enter();
        check("show_enter_state", {13'd0, bus.state_code}, 16'd0);
        check("show_enter_disp", bus.display, 16'h0000);

        // Overflow of the entry buffer drops the oldest nibbles
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h5); key(4'h6);
        check("disp_3456", bus.display, 16'h3456);
        check("digits_sat", {13'd0, bus.digits}, 16'd4);
        enter();
        check("op_a_3456", bus.op_a, 16'h3456);

        // Enter with no digits commits zero, then time out in WAIT
        enter();
        check("op_b_zero", bus.op_b, 16'h0000);
        bus.mac_ready = 1'b1;
        idle();
        bus.mac_ready = 1'b0;
        check("start_pulse2", {15'd0, bus.mac_start}, 16'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            cnt++;
            if (bus.state_code == 3'd4) break;
        end
        check("timeout_cycles", cnt[15:0], 16'd16);
        check("timeout_error", {15'd0, bus.error}, 16'd1);
        check("timeout_disp", bus.display, 16'hEEEE);
        key(4'h7);
        check("show_key_state", {13'd0, bus.state_code}, 16'd0);
        check("show_key_disp", bus.display, 16'h0007);
        check("show_key_err", {15'd0, bus.error}, 16'd0);
        check("show_key_digits", {13'd0, bus.digits}, 16'd1);
        key(4'h8);
        check("disp_0078", bus.display, 16'h0078);
        enter();
        check("op_a_0078", bus.op_a, 16'h0078);

        // Clear beats enter in ENTER_B
        key(4'h2);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        check("clr_state", {13'd0, bus.state_code}, 16'd0);
        check("clr_op_a", bus.op_a, 16'h0000);
        check("clr_disp", bus.display, 16'h0000);
        check("clr_digits", {13'd0, bus.digits}, 16'd0);

        // Enter beats key in ENTER_A
        key(4'h1);
        step(1'b1, 4'hF, 1'b1, 1'b0);
        check("prio_op_a", bus.op_a, 16'h0001);
        check("prio_state", {13'd0, bus.state_code}, 16'd1);
        check("prio_digits", {13'd0, bus.digits}, 16'd0);

        // Async reset mid-WAIT, then a late done and ready are ignored
        key(4'h5);
        enter();
        bus.mac_ready = 1'b1;
        idle();
        check("start_pulse3", {15'd0, bus.mac_start}, 16'd1);
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", {13'd0, bus.state_code}, 16'd0);
        check("arst_ops", bus.op_a | bus.op_b, 16'h0000);
        check("arst_disp", bus.display, 16'h0000);
        check("arst_flags", {13'd0, bus.busy, bus.error, bus.mac_start}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.mac_done   = 1'b1;
        bus.mac_result = 16'h4242;
        for (int i = 0; i < 5; i++) begin
            idle();
            check("late_no_start", {15'd0, bus.mac_start}, 16'd0);
        end
        bus.mac_done  = 1'b0;
        bus.mac_ready = 1'b0;
        check("late_done_state", {13'd0, bus.state_code}, 16'd0);
        check("late_done_disp", bus.display, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
